local_window_gen: RTL and testbench

//  Converts a raster pixel stream (one pixel/cycle max, row-major) into 7x7 neighbourhoods for the bilateral filter.

---
 rtl/bf_pkg.sv | 13 +
 rtl/line_buffer.sv | 28 ++
 rtl/local_window_gen.sv | 118 +++++++++++
 tb/tb_local_window_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared constants for the bilateral-filter front end: 7x7 window geometry
// and the default pixel type.
package bf_pkg;

  localparam int PIX_W_DEF  = 10;
  localparam int WIN        = 7;
  localparam int WIN_TAPS   = WIN * WIN;
  localparam int CENTRE_IDX = WIN_TAPS / 2;
  localparam int LB_LINES   = WIN - 1;

  typedef logic [PIX_W_DEF-1:0] pix_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of storage. Read data is registered and prefetched from the
// address the next pixel will use, so it is ready in the cycle that pixel arrives.
module line_buffer #(
  parameter int PIX_W = 10,
  parameter int DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [PIX_W-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [PIX_W-1:0]         o_rd_data
);

  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rd_data;

  // Read samples the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/local_window_gen.sv
// Raster stream to 7x7 neighbourhood generator; emits only windows fully
// inside the image, one cycle after the pixel that completes them.
module local_window_gen
  import bf_pkg::*;
#(
  parameter int PIX_W      = 10,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIX_W-1:0]                 pixel_in,
  input  logic                             pixel_valid,
  input  logic                             sof,
  output logic [WIN_TAPS-1:0][PIX_W-1:0]   local_window,
  output logic                             local_window_valid,
  output logic                             frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WIN - 1);

  logic [CW-1:0] r_col, w_col, w_col_nxt;
  logic [RW-1:0] r_row, w_row, w_row_nxt;
  logic          w_sof;

  logic [PIX_W-1:0] w_lb_rd [LB_LINES];
  logic [PIX_W-1:0] w_tap   [WIN];

  logic [WIN_TAPS-1:0][PIX_W-1:0] r_win;
  logic                           r_valid;
  logic                           r_done;

  // Position of the pixel presented this cycle; sof forces it to (0,0).
  always_comb begin
    w_sof     = sof & pixel_valid;
    w_col     = w_sof ? '0 : r_col;
    w_row     = w_sof ? '0 : r_row;
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (pixel_valid) begin
      if (w_col == COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  genvar k;
  generate
    for (k = 0; k < LB_LINES; k++) begin : g_lb
      logic [PIX_W-1:0] w_wr_data;
      if (k == 0) begin : g_head
        assign w_wr_data = pixel_in;
      end else begin : g_chain
        assign w_wr_data = w_lb_rd[k-1];
      end

      line_buffer #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_WIDTH)
      ) u_lb (
        .clk       (clk),
        .i_we      (pixel_valid),
        .i_wr_addr (w_col),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_col_nxt),
        .o_rd_data (w_lb_rd[k])
      );

      // Deeper buffers hold older lines, so they feed the upper window rows.
      assign w_tap[LB_LINES-1-k] = w_lb_rd[k];
    end
  endgenerate

  assign w_tap[WIN-1] = pixel_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (pixel_valid) begin
        for (int i = 0; i < WIN; i++) begin
          for (int j = 0; j < WIN - 1; j++) begin
            r_win[i*WIN+j] <= r_win[i*WIN+j+1];
          end
          r_win[i*WIN+WIN-1] <= w_tap[i];
        end
      end
      r_valid <= pixel_valid && (w_row >= ROW_MIN) && (w_col >= COL_MIN);
      r_done  <= pixel_valid && (w_row == ROW_LAST) && (w_col == COL_LAST);
    end
  end

  assign local_window       = r_win;
  assign local_window_valid = r_valid;
  assign frame_done         = r_done;

endmodule

// File: tb/tb_local_window_gen.sv
// Randomised bench for local_window_gen on a 16x12 image; expected windows are
// cut directly out of a model copy of the image written so far.
module tb_local_window_gen;
  import bf_pkg::*;

  localparam int W  = 16;
  localparam int H  = 12;
  localparam int PW = 10;

  typedef logic [WIN_TAPS-1:0][PW-1:0] win_t;

  logic          clk;
  logic          rst;
  logic [PW-1:0] pixel_in;
  logic          pixel_valid;
  logic          sof;
  win_t          local_window;
  logic          local_window_valid;
  logic          frame_done;

  local_window_gen #(
    .PIX_W      (PW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pixel_in           (pixel_in),
    .pixel_valid        (pixel_valid),
    .sof                (sof),
    .local_window       (local_window),
    .local_window_valid (local_window_valid),
    .frame_done         (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [PW-1:0] img [H][W];
  int   m_row, m_col;
  int   cur_r, cur_c;
  bit   exp_valid, exp_done;
  win_t exp_win, prev_win;
  win_t win_q1[$];

  function automatic logic [PW-1:0] pv(int r, int c, int off);
    return PW'(r * 16 + c + off);
  endfunction

  // One clock: drive inputs, let the edge happen, then update the model.
  task automatic step(input bit v, input bit s, input logic [PW-1:0] p);
    @(negedge clk);
    prev_win    = local_window;
    pixel_valid = v;
    sof         = s;
    pixel_in    = p;
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    cur_r     = -1;
    cur_c     = -1;
    if (v) begin
      if (s) begin
        m_row = 0;
        m_col = 0;
      end
      cur_r = m_row;
      cur_c = m_col;
      img[cur_r][cur_c] = p;
      exp_valid = (cur_r >= 6) && (cur_c >= 6);
      exp_done  = (cur_r == H - 1) && (cur_c == W - 1);
      if (exp_valid)
        for (int i = 0; i < WIN; i++)
          for (int j = 0; j < WIN; j++)
            exp_win[i*WIN+j] = img[cur_r-6+i][cur_c-6+j];
      m_col++;
      if (m_col == W) begin
        m_col = 0;
        m_row++;
        if (m_row == H) m_row = 0;
      end
    end
    pixel_valid = 1'b0;
    sof         = 1'b0;
    pixel_in    = PW'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; pixel_valid = 1'b0; sof = 1'b0; pixel_in = '0;
    m_row = 0; m_col = 0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (local_window !== '0) begin n_bad++; $display("FAIL reset_win: got %h want 0", local_window); end
    n_cmp++; if (local_window_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", local_window_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_contiguous();
    int  nv = 0;
    bit  first = 1'b1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, (r == 0 && c == 0), pv(r, c, 0));
        n_cmp++; if (local_window_valid !== exp_valid) begin n_bad++; $display("FAIL t1_valid (%0d,%0d): got %b want %b", cur_r, cur_c, local_window_valid, exp_valid); end
        n_cmp++; if (frame_done !== exp_done) begin n_bad++; $display("FAIL t1_done (%0d,%0d): got %b want %b", cur_r, cur_c, frame_done, exp_done); end
        if (exp_valid) begin
          n_cmp++; if (local_window !== exp_win) begin n_bad++; $display("FAIL t1_win (%0d,%0d): got %h want %h", cur_r, cur_c, local_window, exp_win); end
        end
        if (local_window_valid) begin
          nv++;
          win_q1.push_back(local_window);
        end
        if (exp_valid && first) begin
          first = 1'b0;
          n_cmp++; if (local_window[0] !== PW'(0)) begin n_bad++; $display("FAIL t1_first_w0: got %0d want 0", local_window[0]); end
          n_cmp++; if (local_window[CENTRE_IDX] !== PW'(51)) begin n_bad++; $display("FAIL t1_first_w24: got %0d want 51", local_window[CENTRE_IDX]); end
          n_cmp++; if (local_window[48] !== PW'(102)) begin n_bad++; $display("FAIL t1_first_w48: got %0d want 102", local_window[48]); end
        end
      end
    n_cmp++; if (nv !== 60) begin n_bad++; $display("FAIL t1_count: got %0d want 60", nv); end
  endtask

  task automatic test_gaps();
    int nv = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        while ($urandom_range(0, 99) < 30) begin
          step(1'b0, 1'($urandom), PW'($urandom));
          n_cmp++; if (local_window_valid !== 1'b0) begin n_bad++; $display("FAIL t2_idle_valid: got %b want 0", local_window_valid); end
          n_cmp++; if (local_window !== prev_win) begin n_bad++; $display("FAIL t2_idle_hold: got %h want %h", local_window, prev_win); end
        end
        step(1'b1, (r == 0 && c == 0), pv(r, c, 0));
        n_cmp++; if (local_window_valid !== exp_valid) begin n_bad++; $display("FAIL t2_valid (%0d,%0d): got %b want %b", cur_r, cur_c, local_window_valid, exp_valid); end
        n_cmp++; if (frame_done !== exp_done) begin n_bad++; $display("FAIL t2_done (%0d,%0d): got %b want %b", cur_r, cur_c, frame_done, exp_done); end
        if (exp_valid) begin
          n_cmp++; if (local_window !== exp_win) begin n_bad++; $display("FAIL t2_win (%0d,%0d): got %h want %h", cur_r, cur_c, local_window, exp_win); end
          if (nv < win_q1.size()) begin
            n_cmp++; if (local_window !== win_q1[nv]) begin n_bad++; $display("FAIL t2_order #%0d: got %h want %h", nv, local_window, win_q1[nv]); end
          end
        end
        if (local_window_valid) nv++;
      end
    n_cmp++; if (nv !== 60) begin n_bad++; $display("FAIL t2_count: got %0d want 60", nv); end
  endtask

  task automatic test_line_wrap();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, (r == 0 && c == 0), pv(r, c, 0));
        n_cmp++; if (local_window_valid !== exp_valid) begin n_bad++; $display("FAIL t3_valid (%0d,%0d): got %b want %b", cur_r, cur_c, local_window_valid, exp_valid); end
        if (cur_r == 6 && cur_c == 15) begin
          n_cmp++; if (local_window[CENTRE_IDX] !== PW'(60)) begin n_bad++; $display("FAIL t3_last_centre: got %0d want 60", local_window[CENTRE_IDX]); end
        end
        if (cur_r == 7 && cur_c == 6) begin
          n_cmp++; if (local_window[CENTRE_IDX] !== PW'(67)) begin n_bad++; $display("FAIL t3_wrap_centre: got %0d want 67", local_window[CENTRE_IDX]); end
          n_cmp++; if (local_window[0] !== PW'(16)) begin n_bad++; $display("FAIL t3_wrap_w0: got %0d want 16", local_window[0]); end
        end
      end
  endtask

  task automatic test_sof_restart();
    int nv = 0;
    int first_idx = -1;
    for (int n = 0; n < 49; n++) begin
      step(1'b1, (n == 0), pv(n / W, n % W, 0));
      n_cmp++; if (local_window_valid !== 1'b0) begin n_bad++; $display("FAIL t4_pre_valid #%0d: got %b want 0", n, local_window_valid); end
    end
    for (int n = 0; n < W * H; n++) begin
      step(1'b1, (n == 0), pv(n / W, n % W, 200));
      n_cmp++; if (local_window_valid !== exp_valid) begin n_bad++; $display("FAIL t4_valid (%0d,%0d): got %b want %b", cur_r, cur_c, local_window_valid, exp_valid); end
      if (exp_valid) begin
        n_cmp++; if (local_window !== exp_win) begin n_bad++; $display("FAIL t4_win (%0d,%0d): got %h want %h", cur_r, cur_c, local_window, exp_win); end
      end
      if (local_window_valid) begin
        if (first_idx < 0) begin
          first_idx = n;
          n_cmp++; if (local_window[CENTRE_IDX] !== PW'(251)) begin n_bad++; $display("FAIL t4_first_centre: got %0d want 251", local_window[CENTRE_IDX]); end
        end
        nv++;
      end
    end
    n_cmp++; if (first_idx !== 102) begin n_bad++; $display("FAIL t4_first_idx: got %0d want 102", first_idx); end
    n_cmp++; if (nv !== 60) begin n_bad++; $display("FAIL t4_count: got %0d want 60", nv); end
  endtask

  task automatic test_mid_reset();
    int nv = 0;
    for (int n = 0; n < 7 * W + 8; n++)
      step(1'b1, (n == 0), pv(n / W, n % W, 300));
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (local_window !== '0) begin n_bad++; $display("FAIL t5_rst_win: got %h want 0", local_window); end
    n_cmp++; if (local_window_valid !== 1'b0) begin n_bad++; $display("FAIL t5_rst_valid: got %b want 0", local_window_valid); end
    @(negedge clk);
    rst = 1'b0;
    m_row = 0;
    m_col = 0;
    for (int n = 0; n < W * H; n++) begin
      step(1'b1, 1'b0, pv(n / W, n % W, 100));
      n_cmp++; if (local_window_valid !== exp_valid) begin n_bad++; $display("FAIL t5_valid (%0d,%0d): got %b want %b", cur_r, cur_c, local_window_valid, exp_valid); end
      n_cmp++; if (frame_done !== exp_done) begin n_bad++; $display("FAIL t5_done (%0d,%0d): got %b want %b", cur_r, cur_c, frame_done, exp_done); end
      if (exp_valid) begin
        n_cmp++; if (local_window !== exp_win) begin n_bad++; $display("FAIL t5_win (%0d,%0d): got %h want %h", cur_r, cur_c, local_window, exp_win); end
      end
      if (local_window_valid) nv++;
    end
    n_cmp++; if (nv !== 60) begin n_bad++; $display("FAIL t5_count: got %0d want 60", nv); end
  endtask

  task automatic test_back_to_back();
    int nv = 0;
    int nd = 0;
    for (int f = 0; f < 2; f++)
      for (int n = 0; n < W * H; n++) begin
        step(1'b1, (n == 0), pv(n / W, n % W, 400 * f));
        n_cmp++; if (local_window_valid !== exp_valid) begin n_bad++; $display("FAIL t6_valid f%0d (%0d,%0d): got %b want %b", f, cur_r, cur_c, local_window_valid, exp_valid); end
        n_cmp++; if (frame_done !== exp_done) begin n_bad++; $display("FAIL t6_done f%0d (%0d,%0d): got %b want %b", f, cur_r, cur_c, frame_done, exp_done); end
        if (exp_valid) begin
          n_cmp++; if (local_window !== exp_win) begin n_bad++; $display("FAIL t6_win f%0d (%0d,%0d): got %h want %h", f, cur_r, cur_c, local_window, exp_win); end
        end
        if (local_window_valid) nv++;
        if (frame_done) nd++;
      end
    n_cmp++; if (nv !== 120) begin n_bad++; $display("FAIL t6_count: got %0d want 120", nv); end
    n_cmp++; if (nd !== 2) begin n_bad++; $display("FAIL t6_done_count: got %0d want 2", nd); end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gaps();
    test_line_wrap();
    test_sof_restart();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
